fsm_input_arbiter: RTL and testbench

Round-robin arbiter that shares the single 2-bit-input Moore FSM datapath (clk, reset, in[1:0], out[1:0]) between two requesters. Each granted requester gets a fresh FSM: the arbiter pulses the FSM reset, streams the requester's symbol burst into `in`, samples the FSM `out` after the last symbol, and returns that value as a one-cycle response. It sits between the requester logic and the FSM instance and is the only driver of the FSM's `in` and `reset`.

---
 rtl/fsm_input_arbiter_if.sv | 21 ++
 rtl/fsm_input_arbiter.sv | 122 ++++++++++++
 tb/tb_fsm_input_arbiter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fsm_input_arbiter_if.sv
// Requester-side bus of fsm_input_arbiter: per-lane symbol handshake plus response strobe.
// master = requester logic, slave = arbiter.
interface fsm_input_arbiter_if;
  logic [1:0] req_valid;
  logic [3:0] req_sym;
  logic [1:0] req_last;
  logic [1:0] req_ready;
  logic [1:0] resp_valid;
  logic [1:0] resp_out;
  logic       resp_err;

  modport master (
    output req_valid, req_sym, req_last,
    input  req_ready, resp_valid, resp_out, resp_err
  );

  modport slave (
    input  req_valid, req_sym, req_last,
    output req_ready, resp_valid, resp_out, resp_err
  );
endinterface

// File: rtl/fsm_input_arbiter.sv
// Round-robin share of one Moore FSM between two requesters; burst of N symbols answers at grant+N+3.
// Symbols are taken whenever the owner is valid; a dropped valid mid-burst aborts instead of stalling.
module fsm_input_arbiter #(
  parameter int MAX_LEN = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  fsm_input_arbiter_if.slave   req,
  output logic                 busy,
  output logic                 owner,
  output logic                 fsm_reset,
  output logic [1:0]           fsm_in,
  input  logic [1:0]           fsm_out
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RST     = 3'd1,
    STREAM  = 3'd2,
    CAPTURE = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        owner_nxt;
  logic [7:0]  cnt;
  logic        err;
  logic [1:0]  result;

  logic        own_vld;
  logic        own_last;
  logic [1:0]  own_sym;
  logic [1:0]  own_mask;
  logic        at_max;

  assign own_vld  = req.req_valid[owner];
  assign own_last = req.req_last[owner];
  assign own_sym  = owner ? req.req_sym[3:2] : req.req_sym[1:0];
  assign own_mask = owner ? 2'b10 : 2'b01;
  assign at_max   = (cnt == 8'(MAX_LEN - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      owner <= 1'b1;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    case (state)
      IDLE: begin
        if (req.req_valid != 2'b00) begin
          state_nxt = RST;
          // On a tie the lane that did not win last time gets the grant.
          owner_nxt = (req.req_valid == 2'b11) ? ~owner : req.req_valid[1];
        end
      end
      RST:     state_nxt = STREAM;
      STREAM: begin
        if (!own_vld)      state_nxt = RESP;
        else if (own_last) state_nxt = CAPTURE;
        else if (at_max)   state_nxt = RESP;
      end
      CAPTURE: state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= 8'd0;
      err    <= 1'b0;
      result <= 2'b00;
    end else if (state == STREAM) begin
      if (own_vld) begin
        cnt <= cnt + 8'd1;
      end
      if (!own_vld || (!own_last && at_max)) begin
        err <= 1'b1;
      end
    end else if (state == CAPTURE) begin
      result <= fsm_out;
    end else if (state == RESP) begin
      cnt <= 8'd0;
      err <= 1'b0;
    end
  end

  // The FSM stays in reset alongside the arbiter while reset is held.
  always_comb begin
    busy           = (state != IDLE);
    fsm_reset      = reset;
    fsm_in         = 2'b00;
    req.req_ready  = 2'b00;
    req.resp_valid = 2'b00;
    req.resp_out   = 2'b00;
    req.resp_err   = 1'b0;
    case (state)
      RST: fsm_reset = 1'b1;
      STREAM: begin
        if (own_vld) begin
          req.req_ready = own_mask;
          fsm_in        = own_sym;
        end
      end
      RESP: begin
        req.resp_valid = own_mask;
        req.resp_out   = err ? 2'b00 : result;
        req.resp_err   = err;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fsm_input_arbiter.sv
// Bench for fsm_input_arbiter: directed scenarios plus random bursts on both lanes,
// scored against a burst-level outcome model and a round-robin grant model.
module tb_fsm_input_arbiter;
  localparam int MAX_LEN = 8;
  localparam int BMAX    = MAX_LEN + 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       busy;
  logic       owner;
  logic       fsm_reset;
  logic [1:0] fsm_in;
  logic [1:0] fsm_out;

  fsm_input_arbiter_if bus();

  fsm_input_arbiter #(.MAX_LEN(MAX_LEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (bus),
    .busy      (busy),
    .owner     (owner),
    .fsm_reset (fsm_reset),
    .fsm_in    (fsm_in),
    .fsm_out   (fsm_out)
  );

  always #5 clk = ~clk;

  // FSM stub: out follows the last symbol driven, cleared by reset.
  always @(posedge clk) fsm_out <= fsm_reset ? 2'b00 : fsm_in;

  logic       rv [2];
  logic       rl [2];
  logic [1:0] rs [2];
  assign bus.req_valid = {rv[1], rv[0]};
  assign bus.req_last  = {rl[1], rl[0]};
  assign bus.req_sym   = {rs[1], rs[0]};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Burst descriptors, one per requester.
  logic [1:0] b_sym [2][BMAX];
  int         b_len [2];
  int         b_present [2];
  bit         b_last [2];
  bit         drv_active [2];
  bit         abort_flag = 1'b0;

  // Grant model: whenever the arbiter is idle with requests, pick by round robin.
  bit         m_owner = 1'b1;
  bit         m_pick  = 1'b0;
  int         m_phase = 0;
  logic [1:0] m_mask;

  always @(negedge clk) begin
    if (reset) begin
      m_owner = 1'b1;
      m_phase = 0;
      chk("reset_outs",
          {fsm_reset, busy, owner, bus.req_ready, bus.resp_valid, bus.resp_out, bus.resp_err, fsm_in},
          {1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00});
    end else begin
      m_mask = m_owner ? 2'b10 : 2'b01;
      chk("xlane", {bus.req_ready & ~m_mask, bus.resp_valid & ~m_mask}, 0);
      chk("resp_unexp", bus.resp_valid & ~{drv_active[1], drv_active[0]}, 0);
      if (bus.req_ready == 2'b00) chk("fsm_in_quiet", fsm_in, 0);
      case (m_phase)
        1: begin
          chk("grant", {fsm_reset, busy, owner}, {1'b1, 1'b1, m_pick});
          m_phase = 2;
        end
        2: begin
          chk("rst_pulse", fsm_reset, 0);
          m_phase = 0;
        end
        default: begin
          if (!busy && bus.req_valid != 2'b00) begin
            m_pick  = (bus.req_valid == 2'b11) ? ~m_owner : bus.req_valid[1];
            m_owner = m_pick;
            m_phase = 1;
          end
        end
      endcase
    end
  end

  // Plays one burst on lane i and scores its response against the burst-level outcome.
  task automatic drive(input int i);
    int         idx = 0;
    int         nacc = 0;
    int         first = -1;
    int         budget = 0;
    int         exp_acc;
    bit         done_ok;
    bit         ovf;
    bit         got = 1'b0;
    logic [1:0] exp_out;
    exp_acc = (b_present[i] < MAX_LEN) ? b_present[i] : MAX_LEN;
    done_ok = (b_present[i] == b_len[i]) && b_last[i] && (b_len[i] <= MAX_LEN);
    ovf     = !done_ok && (exp_acc == MAX_LEN);
    exp_out = done_ok ? b_sym[i][b_len[i]-1] : 2'b00;
    drv_active[i] = 1'b1;
    while (!got && !abort_flag && budget < 200) begin
      if (idx < b_present[i]) begin
        rv[i] = 1'b1;
        rs[i] = b_sym[i][idx];
        rl[i] = b_last[i] && (idx == b_len[i] - 1);
      end else begin
        rv[i] = 1'b0;
        rs[i] = 2'b00;
        rl[i] = 1'b0;
      end
      @(negedge clk);
      if (bus.req_ready[i] && idx < BMAX) begin
        chk("sym", fsm_in, b_sym[i][idx]);
        if (first < 0) first = cyc;
        nacc++;
        idx++;
      end
      if (bus.resp_valid[i]) begin
        got = 1'b1;
        chk("resp_out", bus.resp_out, exp_out);
        chk("resp_err", bus.resp_err, !done_ok);
        chk("accepted", nacc, exp_acc);
        chk("latency", cyc - first, exp_acc + (ovf ? 0 : 1));
      end
      @(posedge clk);
      #1;
      budget++;
    end
    rv[i] = 1'b0;
    rs[i] = 2'b00;
    rl[i] = 1'b0;
    drv_active[i] = 1'b0;
    if (!got && !abort_flag) chk("resp_timeout", 0, 1);
  endtask

  task automatic gen(input int i);
    b_len[i] = $urandom_range(1, BMAX);
    for (int k = 0; k < BMAX; k++) b_sym[i][k] = 2'($urandom_range(0, 3));
    b_last[i]    = ($urandom_range(0, 3) != 0);
    b_present[i] = b_len[i];
    if (b_len[i] > 1 && $urandom_range(0, 3) == 0) b_present[i] = $urandom_range(1, b_len[i] - 1);
  endtask

  task automatic set_burst(input int i, input int len, input int present, input bit last);
    b_len[i] = len;
    b_present[i] = present;
    b_last[i] = last;
    for (int k = 0; k < BMAX; k++) b_sym[i][k] = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wait_cycles(2);
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rv[i] = 1'b0;
      rl[i] = 1'b0;
      rs[i] = 2'b00;
      drv_active[i] = 1'b0;
    end
    // Reset with requester 0 already waiting.
    reset = 1'b1;
    rv[0] = 1'b1;
    wait_cycles(3);
    reset = 1'b0;

    set_burst(0, 3, 3, 1'b1);
    b_sym[0][0] = 2'b00;
    b_sym[0][1] = 2'b11;
    b_sym[0][2] = 2'b10;
    drive(0);
    wait_cycles(2);

    // Tie straight after reset: lane 0 first, then lane 1.
    do_reset();
    set_burst(0, 4, 4, 1'b1);
    set_burst(1, 2, 2, 1'b1);
    fork
      drive(0);
      drive(1);
    join
    wait_cycles(1);

    // Lane 1 drops valid after two symbols, then a fresh grant follows.
    set_burst(1, 5, 2, 1'b1);
    drive(1);
    set_burst(1, 3, 3, 1'b1);
    drive(1);

    // Nine symbols with no last: eight taken, overflow error.
    set_burst(0, 9, 9, 1'b0);
    drive(0);
    wait_cycles(1);

    // Reset in the middle of a burst, then a clean burst.
    set_burst(0, 6, 6, 1'b1);
    fork
      drive(0);
      begin
        wait_cycles(4);
        reset = 1'b1;
        abort_flag = 1'b1;
        #1;
        chk("midrst_fsm_reset", fsm_reset, 1);
        wait_cycles(2);
        reset = 1'b0;
      end
    join
    abort_flag = 1'b0;
    wait_cycles(2);
    set_burst(0, 5, 5, 1'b1);
    drive(0);

    for (int it = 0; it < 40; it++) begin
      gen(0);
      gen(1);
      fork
        begin
          wait_cycles($urandom_range(0, 3));
          drive(0);
        end
        begin
          wait_cycles($urandom_range(0, 3));
          drive(1);
        end
      join
    end
    wait_cycles(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (compared %0d)", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
